// File: rtl/alu_pkg_160_163.sv
// Shared op-code encoding, FSM state type and op classification for the sequenced ALU.
package alu_pkg_160_163;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  // Divide by zero short-circuits to a single-cycle result.
  function automatic logic is_iter_op(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/muldiv_iter_160_163.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle for WIDTH cycles.
module muldiv_iter_160_163
  import alu_pkg_160_163::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             hi_nz_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum, addend, rem_sh, rem_sub, step_hi;
  logic [WIDTH-1:0] step_lo;

  // hi holds the product high half (MUL) or the partial remainder (DIV);
  // lo holds the multiplier being consumed (MUL) or dividend/quotient (DIV).
  always_comb begin
    sum     = hi_q + {1'b0, b_q};
    addend  = lo_q[0] ? sum : {1'b0, hi_q[WIDTH-1:0]};
    rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    if (div_q) begin
      if (!rem_sub[WIDTH]) begin
        step_hi = rem_sub;
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh;
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, addend[WIDTH:1]};
      step_lo = {addend[0], lo_q[WIDTH-1:1]};
    end
  end

  // Final step is presented combinationally so the caller registers it on the same edge.
  assign done_o   = (cnt_q == CntW'(1));
  assign result_o = step_lo;
  assign hi_nz_o  = !div_q && (step_hi[WIDTH-1:0] != '0);

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    if (start_i) begin
      cnt_d = CntW'(WIDTH);
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = (op_i == OP_DIV);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_seq_160_163.sv
// Registered WIDTH-bit ALU with flags, valid/ready handshake and iterative MUL/DIV.
module alu_seq_160_163
  import alu_pkg_160_163::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SEL_W-1:0] ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             CARRY_OUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF,
  output logic             DIV0
);

  state_e           state_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q, zero_q, neg_q, ovf_q, div0_q;

  logic [3:0]       sel;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_res, fin_res, md_res;
  logic             sc_c, sc_o, sc_d, fin_c, fin_o, fin_d;
  logic             accept, iter_op, md_start, md_done, md_hi_nz, load_en;

  assign sel      = 4'(ALU_Sel);
  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  assign iter_op  = is_iter_op(sel, B == '0);
  assign md_start = accept && iter_op;

  muldiv_iter_160_163 #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .op_i    (sel),
    .a_i     (A),
    .b_i     (B),
    .done_o  (md_done),
    .result_o(md_res),
    .hi_nz_o (md_hi_nz)
  );

  always_comb begin
    add_w  = {1'b0, A} + {1'b0, B};
    sub_w  = {1'b0, A} - {1'b0, B};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    sc_d   = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_o   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_o   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      // Only reached with B == 0; nonzero divisors go through the iterative path.
      OP_DIV: begin
        sc_res = '1;
        sc_d   = 1'b1;
      end
      OP_SHL: begin
        sc_res = {A[WIDTH-2:0], 1'b0};
        sc_c   = A[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      OP_ROL: begin
        sc_res = {A[WIDTH-2:0], A[WIDTH-1]};
        sc_c   = A[WIDTH-1];
      end
      OP_ROR: begin
        sc_res = {A[0], A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_NAND: sc_res = ~(A & B);
      OP_XNOR: sc_res = ~(A ^ B);
      OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    if (state_q == StExec) begin
      fin_res = md_res;
      fin_c   = md_hi_nz;
      fin_o   = 1'b0;
      fin_d   = 1'b0;
    end else begin
      fin_res = sc_res;
      fin_c   = sc_c;
      fin_o   = sc_o;
      fin_d   = sc_d;
    end
  end

  assign load_en = (accept && !iter_op) || ((state_q == StExec) && md_done);

  // Result registers only load on completion, so they hold their value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      if (load_en) begin
        res_q   <= fin_res;
        carry_q <= fin_c;
        zero_q  <= (fin_res == '0);
        neg_q   <= fin_res[WIDTH-1];
        ovf_q   <= fin_o;
        div0_q  <= fin_d;
      end
      case (state_q)
        StIdle:  if (accept) state_q <= iter_op ? StExec : StDone;
        StExec:  if (md_done) state_q <= StDone;
        StDone:  if (out_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = (state_q == StDone);
  assign ALU_OUT   = res_q;
  assign CARRY_OUT = carry_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign OVF       = ovf_q;
  assign DIV0      = div0_q;

endmodule

// File: tb/tb_alu_seq_160_163.sv
// Scoreboard bench for alu_seq_160_163 at WIDTH=4 and WIDTH=8.
module tb_alu_seq_160_163;
  import alu_pkg_160_163::*;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        o;
    logic        d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv4, rdy4, ov4, or4, c4, z4, n4, o4, d4;
  logic [3:0] a4, b4, s4, r4;
  logic       iv8, rdy8, ov8, or8, c8, z8, n8, o8, d8;
  logic [7:0] a8, b8, r8;
  logic [3:0] s8;

  exp_t sb_q[$];
  int   total = 0;
  int   passed = 0;

  alu_seq_160_163 #(.WIDTH(4), .SEL_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .A(a4), .B(b4), .ALU_Sel(s4),
    .out_valid(ov4), .out_ready(or4), .ALU_OUT(r4), .CARRY_OUT(c4), .ZERO(z4), .NEG(n4),
    .OVF(o4), .DIV0(d4)
  );

  alu_seq_160_163 #(.WIDTH(8), .SEL_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .A(a8), .B(b8), .ALU_Sel(s8),
    .out_valid(ov8), .out_ready(or8), .ALU_OUT(r8), .CARRY_OUT(c8), .ZERO(z8), .NEG(n8),
    .OVF(o8), .DIV0(d8)
  );

  function automatic exp_t mk(input logic [31:0] r, input logic c, z, n, o, d);
    return {r, c, z, n, o, d};
  endfunction

  // Reference model on 64-bit integers, independent of the iterative datapath.
  function automatic exp_t model(input int w, input logic [31:0] ai, bi, input logic [3:0] s);
    longint unsigned mask, msb, a, b, t, r;
    logic c, o, d, sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    a = {32'd0, ai} & mask;
    b = {32'd0, bi} & mask;
    c = 1'b0; o = 1'b0; d = 1'b0; r = 64'd0; t = 64'd0; sr = 1'b0;
    sa = (a & msb) != 0;
    sb = (b & msb) != 0;
    case (s)
      4'd0: begin
        t = a + b; r = t & mask; c = (t >> w) != 0; sr = (r & msb) != 0;
        o = (sa == sb) && (sr != sa);
      end
      4'd1: begin
        r = (a - b) & mask; c = a < b; sr = (r & msb) != 0;
        o = (sa != sb) && (sr != sa);
      end
      4'd2: begin t = a * b; r = t & mask; c = (t >> w) != 0; end
      4'd3: begin
        if (b == 0) begin r = mask; d = 1'b1; end
        else r = a / b;
      end
      4'd4: begin r = (a << 1) & mask; c = sa; end
      4'd5: begin r = a >> 1; c = a[0]; end
      4'd6: begin r = ((a << 1) | (sa ? 64'd1 : 64'd0)) & mask; c = sa; end
      4'd7: begin r = (a >> 1) | (a[0] ? msb : 64'd0); c = a[0]; end
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b) & mask;
      4'd12: r = ~(a & b) & mask;
      4'd13: r = ~(a ^ b) & mask;
      4'd14: r = (a > b) ? 64'd1 : 64'd0;
      default: r = (a == b) ? 64'd1 : 64'd0;
    endcase
    return {r[31:0], c, (r == 0), ((r & msb) != 0), o, d};
  endfunction

  function automatic exp_t obs(input bit w4);
    if (w4) return {28'd0, r4, c4, z4, n4, o4, d4};
    return {24'd0, r8, c8, z8, n8, o8, d8};
  endfunction

  function automatic logic outv(input bit w4);
    return w4 ? ov4 : ov8;
  endfunction

  function automatic logic inrdy(input bit w4);
    return w4 ? rdy4 : rdy8;
  endfunction

  task automatic drive(input bit w4, input logic [31:0] a, b, input logic [3:0] s, input logic v);
    if (w4) begin iv4 = v; a4 = a[3:0]; b4 = b[3:0]; s4 = s; end
    else begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; s8 = s; end
  endtask

  // Issues one op and waits for its result; scrambles operands right after accept.
  task automatic xfer(input bit w4, input logic [31:0] a, b, input logic [3:0] s,
                      output exp_t got, output int lat, output bit tmo);
    int n;
    tmo = 1'b0; lat = 0; got = '0; n = 0;
    drive(w4, a, b, s, 1'b1);
    while (!inrdy(w4) && n < 50) begin @(posedge clk); #1; n++; end
    if (!inrdy(w4)) begin tmo = 1'b1; drive(w4, a, b, s, 1'b0); return; end
    @(posedge clk); #1;
    drive(w4, ~a, ~b, ~s, 1'b0);
    lat = 1;
    while (!outv(w4) && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!outv(w4)) begin tmo = 1'b1; return; end
    got = obs(w4);
    if ((w4 ? or4 : or8) === 1'b1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; or4 = 1'b1; or8 = 1'b1;
    drive(1'b1, 0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b0);
    #12;
    total++;
    if ({ov8, rdy8, obs(1'b0)} !== {1'b0, 1'b1, exp_t'(0)})
      $display("FAIL reset8_in: got %b/%b/%h want 0/1/0", ov8, rdy8, obs(1'b0));
    else passed++;
    total++;
    if ({ov4, rdy4, obs(1'b1)} !== {1'b0, 1'b1, exp_t'(0)})
      $display("FAIL reset4_in: got %b/%b/%h want 0/1/0", ov4, rdy4, obs(1'b1));
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ov8, rdy8, ov4, rdy4} !== 4'b0101)
      $display("FAIL reset_release: got %b want 0101", {ov8, rdy8, ov4, rdy4});
    else passed++;
  endtask

  task automatic test_sweep4();
    logic [3:0] tres [16] = '{4'hC, 4'h8, 4'h4, 4'h5, 4'h4, 4'h5, 4'h5, 4'h5,
                              4'h2, 4'hA, 4'h8, 4'h5, 4'hD, 4'h7, 4'h1, 4'h0};
    logic       tc [16]   = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_t got, exp;
    int lat, elat;
    bit tmo;
    logic [3:0] r;
    for (int i = 0; i < 16; i++) begin
      r = tres[i];
      sb_q.push_back(mk({28'd0, r}, tc[i], r == 4'd0, r[3], 1'b0, 1'b0));
      elat = (i == 2 || i == 3) ? 5 : 1;
      xfer(1'b1, 32'hA, 32'h2, 4'(i), got, lat, tmo);
      exp = sb_q.pop_front();
      total++;
      if (tmo || got !== exp)
        $display("FAIL sweep4 sel=%0d: got %h tmo %0b want %h", i, got, tmo, exp);
      else passed++;
      total++;
      if (lat != elat) $display("FAIL sweep4_lat sel=%0d: got %0d want %0d", i, lat, elat);
      else passed++;
    end
  endtask

  task automatic test_flags8();
    logic [7:0] ta [4] = '{8'h7F, 8'h00, 8'hFF, 8'h80};
    logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
    logic [3:0] ts [4] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB};
    exp_t te [4];
    exp_t got, exp;
    int lat;
    bit tmo;
    te[0] = mk(32'h80, 0, 0, 1, 1, 0);
    te[1] = mk(32'hFF, 1, 0, 1, 0, 0);
    te[2] = mk(32'h00, 1, 1, 0, 0, 0);
    te[3] = mk(32'h7F, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(te[i]);
      xfer(1'b0, {24'd0, ta[i]}, {24'd0, tb[i]}, ts[i], got, lat, tmo);
      exp = sb_q.pop_front();
      total++;
      if (tmo || got !== exp) $display("FAIL flags8 #%0d: got %h tmo %0b want %h", i, got, tmo, exp);
      else passed++;
      total++;
      if (lat != 1) $display("FAIL flags8_lat #%0d: got %0d want 1", i, lat);
      else passed++;
    end
  endtask

  task automatic test_muldiv();
    logic [7:0] ta [5] = '{8'h10, 8'hC8, 8'h55, 8'hFF, 8'h07};
    logic [7:0] tb [5] = '{8'h20, 8'h07, 8'h00, 8'hFF, 8'hC8};
    logic [3:0] ts [5] = '{OP_MUL, OP_DIV, OP_DIV, OP_MUL, OP_DIV};
    int         tl [5] = '{9, 9, 1, 9, 9};
    exp_t te [5];
    exp_t got, exp;
    int lat;
    bit tmo;
    te[0] = mk(32'h00, 1, 1, 0, 0, 0);
    te[1] = mk(32'h1C, 0, 0, 0, 0, 0);
    te[2] = mk(32'hFF, 0, 0, 1, 0, 1);
    te[3] = mk(32'h01, 1, 0, 0, 0, 0);
    te[4] = mk(32'h00, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(te[i]);
      xfer(1'b0, {24'd0, ta[i]}, {24'd0, tb[i]}, ts[i], got, lat, tmo);
      exp = sb_q.pop_front();
      total++;
      if (tmo || got !== exp) $display("FAIL muldiv #%0d: got %h tmo %0b want %h", i, got, tmo, exp);
      else passed++;
      total++;
      if (lat != tl[i]) $display("FAIL muldiv_lat #%0d: got %0d want %0d", i, lat, tl[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    exp_t got, exp, snap;
    int lat;
    bit tmo;
    or8 = 1'b0;
    sb_q.push_back(mk(32'h33, 0, 0, 0, 0, 0));
    xfer(1'b0, 32'h3C, 32'h0F, OP_XOR, got, lat, tmo);
    exp = sb_q.pop_front();
    total++;
    if (tmo || got !== exp) $display("FAIL bp_first: got %h tmo %0b want %h", got, tmo, exp);
    else passed++;
    snap = got;
    sb_q.push_back(mk(32'h30, 0, 0, 0, 0, 0));
    drive(1'b0, 32'h10, 32'h20, OP_ADD, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({ov8, rdy8, obs(1'b0)} !== {1'b1, 1'b0, snap})
        $display("FAIL bp_hold cyc=%0d: got %b/%b/%h want 1/0/%h", i, ov8, rdy8, obs(1'b0), snap);
      else passed++;
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ov8, rdy8} !== 2'b01) $display("FAIL bp_release: got %b want 01", {ov8, rdy8});
    else passed++;
    @(posedge clk); #1;
    drive(1'b0, 32'hEF, 32'hDF, OP_SUB, 1'b0);
    exp = sb_q.pop_front();
    total++;
    if ({ov8, obs(1'b0)} !== {1'b1, exp})
      $display("FAIL bp_next: got %b/%h want 1/%h", ov8, obs(1'b0), exp);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    exp_t got, exp;
    int lat;
    bit tmo, seen;
    sb_q.push_back(mk(32'h00, 1, 1, 0, 0, 0));
    drive(1'b0, 32'h10, 32'h20, OP_MUL, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 32'h10, 32'h20, OP_MUL, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_front());
    total++;
    if ({ov8, rdy8, obs(1'b0)} !== {1'b0, 1'b1, exp_t'(0)})
      $display("FAIL midop_rst: got %b/%b/%h want 0/1/0", ov8, rdy8, obs(1'b0));
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if ({ov8, rdy8, obs(1'b0)} !== {1'b0, 1'b1, exp_t'(0)})
      $display("FAIL midop_release: got %b/%b/%h want 0/1/0", ov8, rdy8, obs(1'b0));
    else passed++;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= ov8; end
    total++;
    if (seen !== 1'b0) $display("FAIL midop_ghost: out_valid got %b want 0", seen);
    else passed++;
    sb_q.push_back(mk(32'h07, 0, 0, 0, 0, 0));
    xfer(1'b0, 32'h03, 32'h04, OP_ADD, got, lat, tmo);
    exp = sb_q.pop_front();
    total++;
    if (tmo || got !== exp) $display("FAIL midop_add: got %h tmo %0b want %h", got, tmo, exp);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t got, exp;
    int lat, elat, cnt;
    bit tmo, w4;
    logic [31:0] a, b;
    logic [3:0] s;
    for (int i = 0; i < 32; i++) begin
      w4 = (i % 4 == 3);
      s = 4'($urandom_range(0, 15));
      a = w4 ? ($urandom & 32'hF) : ($urandom & 32'hFF);
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (w4 ? ($urandom & 32'hF) : ($urandom & 32'hFF));
      elat = (s == OP_MUL || (s == OP_DIV && b != 0)) ? (w4 ? 5 : 9) : 1;
      sb_q.push_back(model(w4 ? 4 : 8, a, b, s));
      xfer(w4, a, b, s, got, lat, tmo);
      exp = sb_q.pop_front();
      total++;
      if (tmo || got !== exp)
        $display("FAIL rand w4=%0b sel=%0d a=%h b=%h: got %h tmo %0b want %h",
                 w4, s, a, b, got, tmo, exp);
      else passed++;
      total++;
      if (lat != elat) $display("FAIL rand_lat sel=%0d: got %0d want %0d", s, lat, elat);
      else passed++;
    end
    // Continuous single-cycle stream with the sink always ready: one result every 2 cycles.
    cnt = 0;
    drive(1'b0, 32'h01, 32'h02, OP_ADD, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov8 && r8 == 8'h03) cnt++;
    end
    drive(1'b0, 32'h01, 32'h02, OP_ADD, 1'b0);
    total++;
    if (cnt != 5) $display("FAIL throughput: got %0d results want 5", cnt);
    else passed++;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep4();
    test_flags8();
    test_muldiv();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
